// File: rtl/uart_cmd_pkg.sv
// Shared types and default constants for the UART host-command decoder.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [7:0] HEAD_DEF   = 8'h55;
    localparam logic [7:0] CMD_WR_DEF = 8'hAA;
    localparam logic [7:0] CMD_RD_DEF = 8'hA5;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned BAUD          = 9600;
    localparam int unsigned BITS_PER_BYTE = 10;   // start + 8 data + stop

    // Inter-byte timeout expressed in clock cycles for a number of byte-times.
    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned baud,
                                                   input int unsigned n_bytes);
        return n_bytes * BITS_PER_BYTE * (clk_hz / baud);
    endfunction

    // Two byte-times at 9600 baud, 50 MHz -> 104160 cycles.
    localparam int unsigned TIMEOUT_DEF = timeout_cycles(CLK_HZ, BAUD, 2);

endpackage

// File: rtl/uart_cmd_decode.sv
// Parses framed host commands (HEAD, CMD, payload) from the UART byte stream
// and drives the SDRAM write FIFO plus write/read trigger pulses.
//
//   state | meaning
//   IDLE  | waiting for HEAD; other bytes dropped silently
//   CMD   | HEAD seen, waiting for the command byte
//   DATA  | write command seen, pushing WR_LEN payload bytes
//   DONE  | last payload byte pushed; one cycle to raise wr_trig
module uart_cmd_decode
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  HEAD    = HEAD_DEF,
    parameter logic [7:0]  CMD_WR  = CMD_WR_DEF,
    parameter logic [7:0]  CMD_RD  = CMD_RD_DEF,
    parameter int unsigned WR_LEN  = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_data,
    output logic       wr_trig,
    output logic       rd_trig,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned    GW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0]  GAP_MAX  = GW'(TIMEOUT - 1);
    localparam logic [7:0]     LAST_IDX = 8'(WR_LEN - 1);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    data_q, data_d;
    logic          wr_trig_q, wr_trig_d;
    logic          rd_trig_q, rd_trig_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [GW-1:0] gap_inc;

    // State, counters and all outputs are registered; reset clears everything.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            wr_trig_q <= 1'b0;
            rd_trig_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            wr_trig_q <= wr_trig_d;
            rd_trig_q <= rd_trig_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, counter and next-output decode; a byte always beats the timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = '0;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        wr_trig_d = 1'b0;
        rd_trig_d = 1'b0;
        err_d     = 1'b0;
        gap_inc   = (gap_q == GAP_MAX) ? gap_q : gap_q + GW'(1);

        unique case (state_q)
            IDLE: begin
                if (po_flag && rx_data == HEAD) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (po_flag) begin
                    if (rx_data == CMD_WR) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else if (rx_data == CMD_RD) begin
                        rd_trig_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        // A repeated HEAD is also an error: no resync.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (gap_q == GAP_MAX) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_inc;
                end
            end
            DATA: begin
                if (po_flag) begin
                    wr_en_d = 1'b1;
                    data_d  = rx_data;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end else if (gap_q == GAP_MAX) begin
                    // Already-pushed bytes stay in the FIFO; consumer flushes on error.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_inc;
                end
            end
            DONE: begin
                wr_trig_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign wfifo_wr_en = wr_en_q;
    assign wfifo_data  = data_q;
    assign wr_trig     = wr_trig_q;
    assign rd_trig     = rd_trig_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Self-checking bench for uart_cmd_decode: frame-level reference model compared
// every cycle, plus literal expectations at the key points of each scenario.
module tb_uart_cmd_decode;

    localparam int unsigned TO    = 50;   // shortened inter-byte timeout
    localparam int unsigned SPACE = 25;   // cycles between strobes (one byte-time)
    localparam int unsigned WRL   = 4;

    logic       sclk    = 1'b0;
    logic       s_rst   = 1'b0;
    logic       po_flag = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wr_trig, rd_trig, frame_err, busy;

    int checks = 0;
    int errors = 0;

    uart_cmd_decode #(
        .HEAD   (8'h55),
        .CMD_WR (8'hAA),
        .CMD_RD (8'hA5),
        .WR_LEN (WRL),
        .TIMEOUT(TO)
    ) dut (
        .sclk       (sclk),
        .s_rst      (s_rst),
        .rx_data    (rx_data),
        .po_flag    (po_flag),
        .wfifo_wr_en(wfifo_wr_en),
        .wfifo_data (wfifo_data),
        .wr_trig    (wr_trig),
        .rd_trig    (rd_trig),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame is kept as the list of bytes accepted so far.
    logic [7:0]  frame[$];
    bit          done_pend = 1'b0;
    int unsigned cyc = 0;
    int unsigned last = 0;
    logic        e_wr_en = 1'b0;
    logic [7:0]  e_data = 8'h00;
    logic        e_wr_trig = 1'b0;
    logic        e_rd = 1'b0;
    logic        e_err = 1'b0;
    logic        e_busy = 1'b0;

    always @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            frame.delete();
            done_pend = 1'b0;
            cyc = 0;
            last = 0;
            e_wr_en = 1'b0; e_data = 8'h00; e_wr_trig = 1'b0;
            e_rd = 1'b0; e_err = 1'b0; e_busy = 1'b0;
        end else begin
            cyc++;
            e_wr_en = 1'b0; e_wr_trig = 1'b0; e_rd = 1'b0; e_err = 1'b0;
            if (done_pend) begin
                e_wr_trig = 1'b1;
                done_pend = 1'b0;
            end else if (frame.size() == 0) begin
                if (po_flag && rx_data == 8'h55) begin
                    frame.push_back(rx_data);
                    last = cyc;
                end
            end else if (po_flag) begin
                last = cyc;
                if (frame.size() == 1) begin
                    if (rx_data == 8'hAA) frame.push_back(rx_data);
                    else begin
                        if (rx_data == 8'hA5) e_rd = 1'b1;
                        else e_err = 1'b1;
                        frame.delete();
                    end
                end else begin
                    frame.push_back(rx_data);
                    e_wr_en = 1'b1;
                    e_data = rx_data;
                    if (frame.size() - 2 == WRL) begin
                        frame.delete();
                        done_pend = 1'b1;
                    end
                end
            end else if (cyc - last >= TO) begin
                e_err = 1'b1;
                frame.delete();
            end
            e_busy = (frame.size() != 0) || done_pend;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge sclk) begin
        if (cyc > 0) begin
            chk("m_wr_en",   wfifo_wr_en, e_wr_en);
            chk("m_data",    wfifo_data,  e_data);
            chk("m_wr_trig", wr_trig,     e_wr_trig);
            chk("m_rd_trig", rd_trig,     e_rd);
            chk("m_err",     frame_err,   e_err);
            chk("m_busy",    busy,        e_busy);
            chk("m_excl",    8'(wr_trig + rd_trig + frame_err) <= 8'd1, 8'd1);
        end
    end

    // Byte strobe sampled by the next rising edge; returns one cycle later.
    task automatic send(input logic [7:0] b);
        po_flag = 1'b1;
        rx_data = b;
        @(negedge sclk);
        po_flag = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic sendg(input logic [7:0] b);
        idle(SPACE - 1);
        send(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 s_rst = 1'b1;
        idle(3);
        chk("rst_wr_en", wfifo_wr_en, 0);
        chk("rst_data",  wfifo_data,  0);
        chk("rst_trig",  {wr_trig, rd_trig, frame_err}, 0);
        chk("rst_busy",  busy, 0);
        s_rst = 1'b0;
        idle(2);

        // Write frame
        send(8'h55);       chk("wr_busy_head", busy, 1);
        sendg(8'hAA);      chk("wr_no_push_cmd", wfifo_wr_en, 0);
        sendg(8'h11);      chk("wr_en_11", wfifo_wr_en, 1); chk("wr_d_11", wfifo_data, 8'h11);
        sendg(8'h22);      chk("wr_d_22", wfifo_data, 8'h22);
        sendg(8'h33);      chk("wr_d_33", wfifo_data, 8'h33);
        sendg(8'h44);      chk("wr_en_44", wfifo_wr_en, 1); chk("wr_d_44", wfifo_data, 8'h44);
        chk("wr_trig_early", wr_trig, 0);
        idle(1);
        chk("wr_trig", wr_trig, 1); chk("wr_busy_end", busy, 0);
        chk("wr_data_hold", wfifo_data, 8'h44); chk("wr_err", frame_err, 0);

        // Read frame
        sendg(8'h55);
        sendg(8'hA5);
        chk("rd_trig", rd_trig, 1); chk("rd_busy", busy, 0); chk("rd_no_push", wfifo_wr_en, 0);
        idle(1);
        chk("rd_pulse_one", rd_trig, 0);

        // Garbage and bad command
        sendg(8'h00);      chk("gb_00", {busy, frame_err}, 0);
        sendg(8'hFF);      chk("gb_ff", {busy, frame_err}, 0);
        sendg(8'h55);      chk("gb_head", busy, 1);
        sendg(8'h3C);      chk("gb_err", frame_err, 1); chk("gb_busy", busy, 0);
        sendg(8'h55);
        sendg(8'hA5);      chk("gb_rd", rd_trig, 1);

        // Timeout: error exactly TO cycles after the last strobe
        sendg(8'h55);
        sendg(8'hAA);
        sendg(8'h11);      chk("to_push", wfifo_wr_en, 1);
        idle(TO - 1);
        chk("to_not_yet", frame_err, 0); chk("to_busy", busy, 1);
        idle(1);
        chk("to_err", frame_err, 1); chk("to_busy_end", busy, 0); chk("to_no_trig", wr_trig, 0);
        idle(5);
        chk("to_no_trig_late", wr_trig, 0);

        // Strobe landing on the timeout cycle keeps the frame alive
        sendg(8'h55);
        sendg(8'hAA);
        idle(TO - 1);
        send(8'h5A);       chk("ka_no_err", frame_err, 0); chk("ka_push", wfifo_data, 8'h5A);
        sendg(8'h6B);
        sendg(8'h7C);
        sendg(8'h8D);
        idle(1);
        chk("ka_wr_trig", wr_trig, 1);

        // Asynchronous reset mid-frame
        sendg(8'h55);
        sendg(8'hAA);
        sendg(8'h11);
        sendg(8'h22);      chk("rs_pre", wfifo_wr_en, 1);
        #2 s_rst = 1'b1;
        #1;
        chk("rs_wr_en", wfifo_wr_en, 0); chk("rs_data", wfifo_data, 0);
        chk("rs_busy", busy, 0); chk("rs_pulses", {wr_trig, rd_trig, frame_err}, 0);
        idle(2);
        s_rst = 1'b0;
        idle(2);
        send(8'h55);
        sendg(8'hAA);
        sendg(8'hA1);      chk("rs_d1", wfifo_data, 8'hA1);
        sendg(8'hB2);
        sendg(8'hC3);      chk("rs_no_trig", wr_trig, 0);
        sendg(8'hD4);      chk("rs_d4", wfifo_data, 8'hD4);
        idle(1);
        chk("rs_wr_trig", wr_trig, 1);

        // Back-to-back write then read
        sendg(8'h55);
        sendg(8'hAA);
        sendg(8'h01);
        sendg(8'h02);
        sendg(8'h03);
        sendg(8'h04);      chk("bb_d4", wfifo_data, 8'h04);
        idle(1);
        chk("bb_wr_trig", wr_trig, 1);
        sendg(8'h55);
        sendg(8'hA5);
        chk("bb_rd_trig", rd_trig, 1); chk("bb_err", frame_err, 0);

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
